rally_controller: RTL and testbench
===================================

// Module: rally_controller
// PURPOSE
//   Sequences one tennis rally on the 16-LED court: serve, ball stepping, hit
//   windows at each end, point scoring and game end. Sits between the debounced
//   button pulses and the LED/score displays.
//   Ball position 0 (LED0) is the left player's end; position 15 (LED15) is the
//   right player's end.
// PARAMETERS
//   TICK_DIV   25_000_000  clk cycles per ball step (>=2)
//   WIN_SCORE  7           points needed to win (1..15)
// PORTS
//   clk          in   1   system clock; all state updates on posedge
//   rst_n        in   1   asynchronous, active-low reset
//   serve_btn    in   1   debounced serve button, 1-cycle pulse
//   hit_left     in   1   debounced left-player hit, 1-cycle pulse
//   hit_right    in   1   debounced right-player hit, 1-cycle pulse
//   ball_leds    out  16  one-hot ball position; 0 when no ball is shown
//   ball_pos     out  4   ball position index
//   score_left   out  4   left player's score
//   score_right  out  4   right player's score
//   server       out  1   0 = left serves, 1 = right serves
//   game_over    out  1   high while in the GAME_OVER state
// BEHAVIOUR
//   Reset (async, rst_n=0): state=SERVE_WAIT, server=0, ball_pos=0,
//     ball_leds=16'h0001, scores=0, game_over=0, tick counter=0, hit_ok=0.
//   Tick counter: counts 0..TICK_DIV-1 in MOVE_R, MOVE_L and POINT.
//     tick=1 when count==TICK_DIV-1, then wraps to 0.
//     Counter clears to 0 on any state entry.
//   ball_leds = 1<<ball_pos, except in POINT and GAME_OVER where it is 0.
//     All outputs are registered.
//   States:
//   SERVE_WAIT:
//     ball_pos = 0 if server=0, 15 if server=1.
//     serve_btn -> MOVE_R (server=0) or MOVE_L (server=1). Position is unchanged.
//   MOVE_R:
//     On tick with ball_pos<15: ball_pos+1.
//     While ball_pos==15, a hit_right pulse sets hit_ok.
//     On tick at ball_pos==15:
//       hit_ok=1 -> MOVE_L, ball_pos=14, hit_ok cleared.
//       Otherwise, left wins the point -> POINT.
//   MOVE_L: mirror of MOVE_R, using position 0, hit_left and a right-player win.
//   Hit rules:
//     A hit before the ball reaches the end position is ignored.
//     A hit from the player the ball is moving away from is ignored.
//     A hit and a tick in the same cycle at the end position count as a hit
//       (reversal).
//     hit_left and hit_right in the same cycle: only the relevant one is
//       evaluated.
//   POINT:
//     On entry, the winner's score increments (saturating at 15).
//     Lasts one tick period with ball_leds=0.
//     On tick:
//       new winner score >= WIN_SCORE -> GAME_OVER.
//       Otherwise -> SERVE_WAIT, with server = loser of the point.
//   GAME_OVER:
//     game_over=1. Scores are held. Hits are ignored.
//     serve_btn -> scores=0, server=0, SERVE_WAIT.
//   Ignored inputs:
//     serve_btn outside SERVE_WAIT and GAME_OVER.
//     Hits in SERVE_WAIT and POINT.
//   Reset mid-rally: immediately returns every output to its reset value.
//   Widths:
//     ball_pos never leaves 0..15; no wrap-around occurs.
//     Score increment never wraps.
// TESTING (TICK_DIV=4, WIN_SCORE=3)
//   1 Reset, then release -> ball_leds=16'h0001, scores=0/0, server=0,
//     game_over=0.
//   2 serve_btn pulse -> ball_leds=16'h0002 4 cycles later;
//     ball_leds=16'h8000 60 cycles after serve.
//   3 In MOVE_R at pos 15, hit_right on the same cycle as the tick ->
//     ball_pos=14 next cycle, state MOVE_L.
//   4 No hit at pos 15 -> on the tick: ball_leds=0, score_left=1;
//     4 cycles later: SERVE_WAIT, server=1, ball_leds=16'h8000.
//   5 hit_right at pos 10, then none at pos 15 -> miss scored
//     (score_left increments); hit_left during MOVE_R has no effect.
//   6 Left wins 3 points -> game_over=1, leds=0; serve_btn -> scores 0/0,
//     ball_leds=16'h0001.
//     Assert rst_n=0 at pos 7 mid-rally -> reset values present asynchronously.

Source files
------------

// File: rtl/rally_controller.sv
// rally_controller: one tennis rally on a 16-LED court.
// The serve, ball stepping, hit windows at both ends, point scoring and game end
// are all handled here. Every output comes straight from a register.
module rally_controller #(
   parameter int TICK_DIV  = 25_000_000,
   parameter int WIN_SCORE = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        serve_btn,
   input  logic        hit_left,
   input  logic        hit_right,
   output logic [15:0] ball_leds,
   output logic [3:0]  ball_pos,
   output logic [3:0]  score_left,
   output logic [3:0]  score_right,
   output logic        server,
   output logic        game_over
);
   localparam int            CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [3:0]    WIN_PTS   = 4'(WIN_SCORE);

   typedef enum logic [2:0] {
      S_SERVE_WAIT,
      S_MOVE_R,
      S_MOVE_L,
      S_POINT,
      S_GAME_OVER
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    pos_q, pos_d;
   logic [3:0]    score_l_q, score_l_d;
   logic [3:0]    score_r_q, score_r_d;
   logic          server_q, server_d;
   logic          hit_ok_q, hit_ok_d;
   logic          winner_q, winner_d;     // 0 = left won the last point
   logic [15:0]   leds_q, leds_d;
   logic          game_over_q, game_over_d;
   logic          counting;
   logic          tick;

   // Scores stop at 15 instead of wrapping.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   assign counting = (state_q == S_MOVE_R) || (state_q == S_MOVE_L) || (state_q == S_POINT);
   assign tick     = counting && (cnt_q == TICK_LAST);

   // Next-state, rally rules, step counter and registered-output values.
   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      server_d    = server_q;
      hit_ok_d    = hit_ok_q;
      winner_d    = winner_q;
      cnt_d       = '0;
      leds_d      = '0;
      game_over_d = 1'b0;

      case (state_q)
         S_SERVE_WAIT: begin
            if (serve_btn) state_d = server_q ? S_MOVE_L : S_MOVE_R;
         end
         S_MOVE_R: begin
            if (tick) begin
               if (pos_q != 4'd15) begin
                  pos_d = pos_q + 4'd1;
               end else if (hit_ok_q || hit_right) begin
                  // A hit landing on the tick still counts as a return.
                  state_d  = S_MOVE_L;
                  pos_d    = 4'd14;
                  hit_ok_d = 1'b0;
               end else begin
                  state_d   = S_POINT;
                  winner_d  = 1'b0;
                  score_l_d = sat_inc(score_l_q);
                  hit_ok_d  = 1'b0;
               end
            end else if (pos_q == 4'd15 && hit_right) begin
               hit_ok_d = 1'b1;
            end
         end
         S_MOVE_L: begin
            if (tick) begin
               if (pos_q != 4'd0) begin
                  pos_d = pos_q - 4'd1;
               end else if (hit_ok_q || hit_left) begin
                  state_d  = S_MOVE_R;
                  pos_d    = 4'd1;
                  hit_ok_d = 1'b0;
               end else begin
                  state_d   = S_POINT;
                  winner_d  = 1'b1;
                  score_r_d = sat_inc(score_r_q);
                  hit_ok_d  = 1'b0;
               end
            end else if (pos_q == 4'd0 && hit_left) begin
               hit_ok_d = 1'b1;
            end
         end
         S_POINT: begin
            if (tick) begin
               if ((winner_q ? score_r_q : score_l_q) >= WIN_PTS) begin
                  state_d = S_GAME_OVER;
               end else begin
                  // The player who lost the point serves next.
                  state_d  = S_SERVE_WAIT;
                  server_d = ~winner_q;
                  pos_d    = winner_q ? 4'd0 : 4'd15;
               end
            end
         end
         S_GAME_OVER: begin
            if (serve_btn) begin
               state_d   = S_SERVE_WAIT;
               score_l_d = '0;
               score_r_d = '0;
               server_d  = 1'b0;
               pos_d     = 4'd0;
            end
         end
         default: state_d = S_SERVE_WAIT;
      endcase

      // Counter restarts on every state entry, including a reversal.
      if (counting && state_d == state_q && !tick) cnt_d = cnt_q + 1'b1;

      if (state_d != S_POINT && state_d != S_GAME_OVER) leds_d = 16'h0001 << pos_d;
      game_over_d = (state_d == S_GAME_OVER);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_SERVE_WAIT;
         cnt_q       <= '0;
         pos_q       <= 4'd0;
         score_l_q   <= 4'd0;
         score_r_q   <= 4'd0;
         server_q    <= 1'b0;
         hit_ok_q    <= 1'b0;
         winner_q    <= 1'b0;
         leds_q      <= 16'h0001;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pos_q       <= pos_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
         server_q    <= server_d;
         hit_ok_q    <= hit_ok_d;
         winner_q    <= winner_d;
         leds_q      <= leds_d;
         game_over_q <= game_over_d;
      end
   end

   assign ball_leds   = leds_q;
   assign ball_pos    = pos_q;
   assign score_left  = score_l_q;
   assign score_right = score_r_q;
   assign server      = server_q;
   assign game_over   = game_over_q;
endmodule

// File: tb/tb_rally_controller.sv
// tb_rally_controller: the stimulus process drives the inputs on the falling edge.
// It also advances a rally model that runs on plain rules and queues the
// expected output snapshot. A separate monitor pops each snapshot after the next
// rising edge and compares it with the outputs.
module tb_rally_controller;
   localparam int TD = 4;
   localparam int WS = 3;
   localparam logic [29:0] RST_SNAP = {16'h0001, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        serve_btn = 1'b0;
   logic        hit_left = 1'b0;
   logic        hit_right = 1'b0;
   logic [15:0] ball_leds;
   logic [3:0]  ball_pos, score_left, score_right;
   logic        server, game_over;

   always #5 clk = ~clk;

   rally_controller #(.TICK_DIV(TD), .WIN_SCORE(WS)) dut (
      .clk(clk), .rst_n(rst_n), .serve_btn(serve_btn),
      .hit_left(hit_left), .hit_right(hit_right),
      .ball_leds(ball_leds), .ball_pos(ball_pos),
      .score_left(score_left), .score_right(score_right),
      .server(server), .game_over(game_over)
   );

   int total = 0;
   int bad = 0;
   logic [29:0] exp_q[$];

   // Rally model: mode 0 waiting for serve, 1 ball in flight, 2 point shown, 3 game over.
   int m_mode, m_t, m_pos, m_dir, m_server, m_armed, m_winner;
   int m_score[2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [29:0] snap_act();
      return {ball_leds, ball_pos, score_left, score_right, server, game_over};
   endfunction

   function automatic logic [29:0] model_snap();
      logic [15:0] leds;
      leds = (m_mode >= 2) ? 16'h0000 : (16'h0001 << m_pos);
      return {leds, 4'(m_pos), 4'(m_score[0]), 4'(m_score[1]), 1'(m_server), m_mode == 3};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_t = 0; m_pos = 0; m_dir = 1; m_server = 0; m_armed = 0; m_winner = 0;
      m_score[0] = 0; m_score[1] = 0;
   endtask

   task automatic model_step(input logic s, input logic hl, input logic hr);
      bit tick, entered, hit;
      int end_pos;
      tick = (m_mode == 1 || m_mode == 2) && (m_t == TD - 1);
      entered = 0;
      end_pos = (m_dir > 0) ? 15 : 0;
      hit = (m_dir > 0) ? hr : hl;
      case (m_mode)
         0: if (s) begin m_mode = 1; m_dir = m_server ? -1 : 1; entered = 1; end
         1: begin
            if (tick) begin
               if (m_pos != end_pos) m_pos += m_dir;
               else if (m_armed || hit) begin
                  m_dir = -m_dir; m_pos += m_dir; m_armed = 0; entered = 1;
               end else begin
                  m_winner = (m_dir > 0) ? 0 : 1;
                  if (m_score[m_winner] < 15) m_score[m_winner]++;
                  m_armed = 0; m_mode = 2; entered = 1;
               end
            end else if (m_pos == end_pos && hit) m_armed = 1;
         end
         2: if (tick) begin
            if (m_score[m_winner] >= WS) m_mode = 3;
            else begin
               m_mode = 0; m_server = 1 - m_winner; m_pos = m_server ? 15 : 0;
            end
            entered = 1;
         end
         default: if (s) begin
            m_score[0] = 0; m_score[1] = 0; m_server = 0; m_pos = 0; m_mode = 0; entered = 1;
         end
      endcase
      if (entered || !(m_mode == 1 || m_mode == 2)) m_t = 0;
      else m_t = (m_t + 1) % TD;
   endtask

   // One clock of stimulus: drive inputs, advance the model, queue expectation.
   task automatic cycle(input logic s, input logic hl, input logic hr);
      @(negedge clk);
      serve_btn = s; hit_left = hl; hit_right = hr;
      if (rst_n) model_step(s, hl, hr);
      else model_reset();
      exp_q.push_back(model_snap());
   endtask

   task automatic peek();
      @(posedge clk);
      #2;
   endtask

   task automatic step_peek(input logic s, input logic hl, input logic hr);
      cycle(s, hl, hr);
      peek();
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst_n = 1'b1; serve_btn = 1'b0; hit_left = 1'b0; hit_right = 1'b0;
      model_step(1'b0, 1'b0, 1'b0);
      exp_q.push_back(model_snap());
   endtask

   task automatic do_async_reset(input int hold);
      @(negedge clk);
      serve_btn = 1'b0; hit_left = 1'b0; hit_right = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("async_reset", 32'(snap_act()), 32'(RST_SNAP));
      model_reset();
      exp_q.push_back(model_snap());
      repeat (hold) cycle(1'b0, 1'b0, 1'b0);
      release_rst();
   endtask

   // Monitor: one comparison per clock whenever an expectation is pending.
   initial begin
      logic [29:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle", 32'(snap_act()), 32'(e));
         end
      end
   end

   initial begin
      model_reset();
      repeat (2) cycle(1'b0, 1'b0, 1'b0);
      chk("reset_held", 32'(snap_act()), 32'(RST_SNAP));
      release_rst();
      peek();
      chk("reset_state", 32'(snap_act()), 32'(RST_SNAP));

      // Serve: first step after one tick period, far end after 15 periods.
      step_peek(1'b1, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      step_peek(1'b0, 1'b0, 1'b0);
      chk("first_step_leds", 32'(ball_leds), 32'h0002);
      repeat (55) cycle(1'b0, 1'b0, 1'b0);
      step_peek(1'b0, 1'b0, 1'b0);
      chk("far_end_leds", 32'(ball_leds), 32'h8000);

      // Hit landing on the same cycle as the tick reverses the ball.
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      step_peek(1'b0, 1'b0, 1'b1);
      chk("reverse_pos", 32'(ball_pos), 32'd14);

      // Left misses: right scores, left serves next from position 0.
      for (int i = 0; i < 200 && ball_pos != 4'd0; i++) step_peek(1'b0, 1'b0, 1'b0);
      chk("reach_left_end", 32'(ball_pos), 32'd0);
      for (int i = 0; i < 20 && ball_leds != 16'h0; i++) step_peek(1'b0, 1'b0, 1'b0);
      chk("right_point", 32'({ball_leds, score_left, score_right}), 32'({16'h0, 4'd0, 4'd1}));
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      step_peek(1'b0, 1'b0, 1'b0);
      chk("serve_left_again", 32'({ball_leds, 3'b0, server}), 32'({16'h0001, 4'd0}));

      // Early hit_right and wrong-side hit_left are ignored; right misses.
      step_peek(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 200 && ball_pos != 4'd10; i++) step_peek(1'b0, 1'b0, 1'b0);
      step_peek(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 200 && ball_pos != 4'd15; i++) step_peek(1'b0, 1'b1, 1'b0);
      chk("reach_right_end", 32'(ball_pos), 32'd15);
      for (int i = 0; i < 20 && ball_leds != 16'h0; i++) step_peek(1'b0, 1'b1, 1'b0);
      chk("left_point", 32'({score_left, score_right}), 32'({4'd1, 4'd1}));
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      step_peek(1'b0, 1'b0, 1'b0);
      chk("serve_right", 32'({ball_leds, 3'b0, server}), 32'({16'h8000, 4'd1}));

      // Left always returns, right never does: left takes the game.
      for (int i = 0; i < 3000 && !game_over; i++) step_peek(ball_leds != 16'h0, 1'b1, 1'b0);
      chk("game_over", 32'({game_over, ball_leds, score_left, score_right}),
          32'({1'b1, 16'h0, 4'(WS), 4'd1}));
      step_peek(1'b0, 1'b1, 1'b1);
      chk("game_over_hold", 32'({game_over, score_left}), 32'({1'b1, 4'(WS)}));
      step_peek(1'b1, 1'b0, 1'b0);
      chk("new_game", 32'({game_over, ball_leds, score_left, score_right, server}),
          32'({1'b0, 16'h0001, 4'd0, 4'd0, 1'b0}));

      // Reset in the middle of a rally.
      step_peek(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 200 && ball_pos != 4'd7; i++) step_peek(1'b0, 1'b0, 1'b0);
      chk("reach_pos7", 32'(ball_pos), 32'd7);
      do_async_reset(2);
      peek();
      chk("after_mid_reset", 32'(snap_act()), 32'(RST_SNAP));

      // Random play against the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 999) == 0) do_async_reset(int'($urandom_range(0, 2)));
         else cycle($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 5) == 0);
      end

      cycle(1'b0, 1'b0, 1'b0);
      peek();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
